// File: rtl/jtflane_romresp_pkg.sv
// ----------------------------------------------------------------------------
// jtflane_romresp_pkg
//   Shared types and constants for the Fast Lane ROM responder:
//     state_e    : line-fetch FSM states (IDLE, REQ, RD0, RD1)
//     LINE_W     : cached line width in bits (two 16-bit SDRAM words)
//     BYTE_SEL_W : width of the byte select taken from the client address
//     byte_pick  : byte lane mux used by every cache line
// ----------------------------------------------------------------------------
package jtflane_romresp_pkg;

  localparam int LINE_W     = 32;
  localparam int BYTE_SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RD0  = 2'd2,
    ST_RD1  = 2'd3
  } state_e;

  // Byte 0 lives in the low half of the first SDRAM word, byte 3 in the
  // high half of the second word.
  function automatic logic [7:0] byte_pick(input logic [LINE_W-1:0]     line,
                                           input logic [BYTE_SEL_W-1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = line[7:0];
      2'd1:    b = line[15:8];
      2'd2:    b = line[23:16];
      default: b = line[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtflane_romresp_line.sv
// ----------------------------------------------------------------------------
// jtflane_romresp_line
//   One cache line of the ROM responder: tag, 32 data bits and a valid bit,
//   with the hit compare and the byte lane mux.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   lookup_tag_i  : tag of the current client address
//   byte_sel_i    : client address bits [1:0]
//   hit_o         : line valid and tag matches lookup_tag_i
//   byte_o        : selected byte of the stored line
//   inv_i         : clear valid (a replacement fetch is starting)
//   wr_lo_i       : store wdata_i into bits [15:0]
//   wr_hi_i       : store wdata_i into bits [31:16], load fill_tag_i, set valid
//   fill_tag_i    : tag of the line being fetched
//   wdata_i       : SDRAM read word
// ----------------------------------------------------------------------------
module jtflane_romresp_line
  import jtflane_romresp_pkg::*;
#(
  parameter int TW = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TW-1:0]         lookup_tag_i,
  input  logic [BYTE_SEL_W-1:0] byte_sel_i,
  output logic                  hit_o,
  output logic [7:0]            byte_o,
  input  logic                  inv_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic [TW-1:0]         fill_tag_i,
  input  logic [15:0]           wdata_i
);

  logic              valid_q, valid_d;
  logic [TW-1:0]     tag_q,   tag_d;
  logic [LINE_W-1:0] data_q,  data_d;

  // NOTE: every variable gets its hold value before any condition, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv_i) begin
      valid_d = 1'b0;
    end
    if (wr_lo_i) begin
      data_d[15:0] = wdata_i;
    end
    // The upper word is the last beat, so the line becomes usable here.
    if (wr_hi_i) begin
      data_d[31:16] = wdata_i;
      tag_d         = fill_tag_i;
      valid_d       = 1'b1;
    end
  end

  // NOTE: the line storage is only a few flops, so it is reset along with
  // the control state; reset data reads back as zero rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the values
      // present before the edge, regardless of statement order.
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign byte_o = byte_pick(data_q, byte_sel_i);

endmodule

// File: rtl/jtflane_rom_resp.sv
// ----------------------------------------------------------------------------
// jtflane_rom_resp
//   Responder for a byte-wide game ROM request port. Requests are answered
//   combinationally from a small line cache; a miss fetches a 2-word, 32-bit
//   line from the 16-bit SDRAM bank port.
//
// Build option
//   JTFLANE_ROMRESP_2LINE_EN : two lines with a 1-bit LRU replacement pointer.
//                              Undefined: a single line, no LRU state.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   rom_addr    : client byte address
//   rom_cs      : client request, held until rom_ok
//   rom_data    : byte at rom_addr (meaningful only while rom_ok)
//   rom_ok      : rom_data valid for the current rom_addr (same cycle)
//   sdram_req   : line fetch request
//   sdram_addr  : OFFSET + first word address of the line being fetched
//   sdram_ack   : arbiter accepted the request
//   sdram_dok   : sdram_data valid, one pulse per word
//   sdram_data  : SDRAM read word
// ----------------------------------------------------------------------------
module jtflane_rom_resp
  import jtflane_romresp_pkg::*;
#(
  parameter int             AW     = 17,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  rom_addr,
  input  logic           rom_cs,
  output logic [7:0]     rom_data,
  output logic           rom_ok,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           sdram_dok,
  input  logic [15:0]    sdram_data
);

  localparam int TW = AW - BYTE_SEL_W;

`ifdef JTFLANE_ROMRESP_2LINE_EN
  localparam int NLINES = 2;
`else
  localparam int NLINES = 1;
`endif

  logic [TW-1:0]         rom_tag;
  logic [BYTE_SEL_W-1:0] rom_sel;

  logic [NLINES-1:0] hit;
  logic [NLINES-1:0] inv, wr_lo, wr_hi;
  logic [NLINES-1:0] vic_new_oh;  // line a miss detected now will replace
  logic [NLINES-1:0] vic_oh;      // line the fetch in flight is filling
  logic [7:0]        line_byte [NLINES];
  logic              hit_any;

  state_e        state_q, state_d;
  logic [TW-1:0] miss_tag_q, miss_tag_d;

  assign rom_tag = rom_addr[AW-1:BYTE_SEL_W];
  assign rom_sel = rom_addr[BYTE_SEL_W-1:0];

  // --------------------------------------------------------------------------
  // Line storage
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
    jtflane_romresp_line #(
      .TW (TW)
    ) u_line (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_tag_i (rom_tag),
      .byte_sel_i   (rom_sel),
      .hit_o        (hit[gi]),
      .byte_o       (line_byte[gi]),
      .inv_i        (inv[gi]),
      .wr_lo_i      (wr_lo[gi]),
      .wr_hi_i      (wr_hi[gi]),
      .fill_tag_i   (miss_tag_q),
      .wdata_i      (sdram_data)
    );
  end

  assign hit_any = |hit;
  assign rom_ok  = rom_cs & hit_any;

  // Fills only happen on a miss, so two lines never hold the same tag and
  // at most one hit bit is set.
  always_comb begin
    rom_data = line_byte[0];
    for (int i = 1; i < NLINES; i++) begin
      if (hit[i]) begin
        rom_data = line_byte[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Replacement choice
  // --------------------------------------------------------------------------
`ifdef JTFLANE_ROMRESP_2LINE_EN
  // lru_q names the line to replace next. victim_q freezes that choice for
  // the whole fetch so the fill lands in the line that was invalidated.
  logic lru_q, lru_d;
  logic victim_q, victim_d;

  assign vic_new_oh = lru_q    ? 2'b10 : 2'b01;
  assign vic_oh     = victim_q ? 2'b10 : 2'b01;

  always_comb begin
    lru_d    = lru_q;
    victim_d = victim_q;
    if (|inv) begin
      victim_d = lru_q;
    end
    // A served hit makes the other line the older one.
    if (rom_ok) begin
      lru_d = ~hit[1];
    end
    // The freshly filled line is the newest; this wins over a same-cycle
    // hit on the other line.
    if (|wr_hi) begin
      lru_d = ~victim_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q    <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      lru_q    <= lru_d;
      victim_q <= victim_d;
    end
  end
`else
  assign vic_new_oh = 1'b1;
  assign vic_oh     = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Line fetch FSM
  // --------------------------------------------------------------------------
  // A started burst always runs to completion with the latched tag, even if
  // the client drops rom_cs or moves to another line; IDLE then looks at
  // whatever address is presented.
  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    inv        = '0;
    wr_lo      = '0;
    wr_hi      = '0;
    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit_any) begin
          miss_tag_d = rom_tag;
          // Drop the victim now so it can never hit with half-written data.
          inv        = vic_new_oh;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // A dok arriving with the ack belongs to nothing and is ignored.
        if (sdram_ack) begin
          state_d = ST_RD0;
        end
      end
      ST_RD0: begin
        if (sdram_dok) begin
          wr_lo   = vic_oh;
          state_d = ST_RD1;
        end
      end
      ST_RD1: begin
        if (sdram_dok) begin
          wr_hi   = vic_oh;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  assign sdram_req  = (state_q == ST_REQ);
  assign sdram_addr = OFFSET + SDW'({miss_tag_q, 1'b0});

endmodule
